// File: rtl/lab3_step_subtractor_seq.sv
// rtl/lab3_step_subtractor_seq.sv - steps an operand down by a constant STEP, n times, one subtraction per clock
module lab3_step_subtractor_seq #(
  parameter int WIDTH = 3,
  parameter int STEP  = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_value,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             sat_mode,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             zero
);

  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] rem;
  logic             mode_q;
  logic             borrow_q;
  logic             accept;
  logic             under;
  logic [WIDTH-1:0] acc_nxt;

  // Underflow is judged on the pre-subtraction value; saturation clamps to 0.
  assign under   = (acc < STEP_V);
  assign acc_nxt = (mode_q && under) ? '0 : (acc - STEP_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = (repeat_cnt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (rem == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      rem      <= '0;
      mode_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      acc      <= start_value;
      rem      <= repeat_cnt;
      mode_q   <= sat_mode;
      borrow_q <= 1'b0;
    end else if (busy) begin
      acc <= acc_nxt;
      rem <= rem - CNT_W'(1);
      if (under) begin
        borrow_q <= 1'b1;
      end
    end
  end

  assign result = acc;
  assign borrow = borrow_q;
  assign zero   = (acc == '0);

endmodule

// File: tb/tb_lab3_step_subtractor_seq.sv
// tb/tb_lab3_step_subtractor_seq.sv - directed vector bench for lab3_step_subtractor_seq (WIDTH=3, STEP=2)
module tb_lab3_step_subtractor_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] start_value;
  logic [3:0] repeat_cnt;
  logic       sat_mode;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [2:0] result;
  logic       borrow;
  logic       zero;

  int checks;
  int errors;

  lab3_step_subtractor_seq #(.WIDTH(3), .STEP(2), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_value(start_value),
    .repeat_cnt (repeat_cnt),
    .sat_mode   (sat_mode),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .borrow     (borrow),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sv;
    logic [3:0] cnt;
    logic       mode;
    logic [2:0] res;
    logic       brw;
    int         lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_borrow"}, int'(borrow), 0);
    check({tag, "_zero"}, int'(zero), 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  lat;
    bit  busy_seen;
    @(negedge clk);
    start       = 1'b1;
    start_value = v.sv;
    repeat_cnt  = v.cnt;
    sat_mode    = v.mode;
    @(posedge clk);
    #1;
    start     = 1'b0;
    lat       = 1;
    busy_seen = busy;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      busy_seen = busy_seen | busy;
    end
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    check($sformatf("v%0d_result", idx), int'(result), int'(v.res));
    check($sformatf("v%0d_borrow", idx), int'(borrow), int'(v.brw));
    check($sformatf("v%0d_zero", idx), int'(zero), (v.res == 3'd0) ? 1 : 0);
    if (v.cnt == 4'd0) check($sformatf("v%0d_busy_seen", idx), int'(busy_seen), 0);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_done_one_cycle", idx), int'(done), 0);
    check($sformatf("v%0d_in_ready_after", idx), int'(in_ready), 1);
    check($sformatf("v%0d_result_hold", idx), int'(result), int'(v.res));
  endtask

  // exp_seq holds result after E0..E3, element k at bits [3k+2:3k].
  task automatic run_trace(input string tag, input logic [2:0] sv, input logic mode,
                           input logic [11:0] exp_seq);
    @(negedge clk);
    start       = 1'b1;
    start_value = sv;
    repeat_cnt  = 4'd3;
    sat_mode    = mode;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      check($sformatf("%s_trace%0d", tag, k), int'(result), int'(exp_seq[3*k +: 3]));
    end
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_borrow"}, int'(borrow), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    bit  done_seen;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    start_value = '0;
    repeat_cnt  = '0;
    sat_mode    = 1'b0;

    vecs[0] = '{sv: 3'd7, cnt: 4'd1,  mode: 1'b0, res: 3'd5, brw: 1'b0, lat: 2};
    vecs[1] = '{sv: 3'd3, cnt: 4'd3,  mode: 1'b0, res: 3'd5, brw: 1'b1, lat: 4};
    vecs[2] = '{sv: 3'd3, cnt: 4'd3,  mode: 1'b1, res: 3'd0, brw: 1'b1, lat: 4};
    vecs[3] = '{sv: 3'd6, cnt: 4'd0,  mode: 1'b0, res: 3'd6, brw: 1'b0, lat: 1};
    vecs[4] = '{sv: 3'd0, cnt: 4'd15, mode: 1'b0, res: 3'd2, brw: 1'b1, lat: 16};
    vecs[5] = '{sv: 3'd7, cnt: 4'd15, mode: 1'b1, res: 3'd0, brw: 1'b1, lat: 16};
    vecs[6] = '{sv: 3'd6, cnt: 4'd3,  mode: 1'b1, res: 3'd0, brw: 1'b0, lat: 4};
    vecs[7] = '{sv: 3'd2, cnt: 4'd1,  mode: 1'b0, res: 3'd0, brw: 1'b0, lat: 2};
    vecs[8] = '{sv: 3'd1, cnt: 4'd1,  mode: 1'b0, res: 3'd7, brw: 1'b1, lat: 2};

    #2;
    check_idle_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    run_trace("wrap_tr", 3'd3, 1'b0, {3'd5, 3'd7, 3'd1, 3'd3});
    run_trace("sat_tr",  3'd3, 1'b1, {3'd0, 3'd0, 3'd1, 3'd3});

    // Asynchronous reset between edges, mid-RUN.
    @(negedge clk);
    start       = 1'b1;
    start_value = 3'd5;
    repeat_cnt  = 4'd10;
    sat_mode    = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("mid_run_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    @(negedge clk);
    rst_n     = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      done_seen = done_seen | done;
    end
    check("no_done_after_rst", int'(done_seen), 0);
    check_idle_outputs("post_rst");

    // Requests during RUN and DONE are dropped; one held into IDLE is taken.
    @(negedge clk);
    start       = 1'b1;
    start_value = 3'd6;
    repeat_cnt  = 4'd4;
    sat_mode    = 1'b0;
    @(posedge clk);
    #1;
    start_value = 3'd1;
    repeat_cnt  = 4'd2;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("drop_in_ready_e%0d", k), int'(in_ready), 0);
      check($sformatf("drop_result_e%0d", k), int'(result), (6 - 2 * k + 8) % 8);
    end
    check("drop_done", int'(done), 1);
    check("drop_borrow", int'(borrow), 1);
    @(posedge clk);
    #1;
    check("drop_idle_in_ready", int'(in_ready), 1);
    check("drop_idle_result", int'(result), 6);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("held_accept_busy", int'(busy), 1);
    check("held_accept_result", int'(result), 1);
    check("held_accept_borrow", int'(borrow), 0);
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("held_op_edges", n, 2);
    check("held_op_result", int'(result), 5);
    check("held_op_borrow", int'(borrow), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab3_step_subtractor_seq.md
# lab3_step_subtractor_seq

Sequential, parametrised successor to the lab's fixed constant-subtract dataflow circuit. Loads an operand through a valid/ready handshake, subtracts a compile-time STEP from it a programmable number of times (one subtraction per clock), then reports the result with a one-cycle done pulse, a sticky borrow flag and a zero flag. Underflow either wraps modulo 2^WIDTH or saturates at 0, selected per operation. It sits in lab datapaths wherever an operand must be stepped down by a constant under control logic, not combinationally.

## Interface
- WIDTH, 3, operand/result width in bits; legal range 2 and up.
- STEP, 2, constant subtrahend; legal range 0 to 2^WIDTH-1.
- CNT_W, 4, width of the repeat count.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request valid; a request is accepted on a rising edge where start=1 and in_ready=1.
- start_value  input  WIDTH  initial operand, sampled on accept.
- repeat_cnt  input  CNT_W  number of subtractions n, sampled on accept.
- sat_mode  input  1  0 means wrap, 1 means saturate at 0; sampled on accept and held for the whole operation.
- in_ready  output  1  high iff the FSM is in IDLE.
- busy  output  1  high iff the FSM is in RUN.
- done  output  1  high for exactly one cycle, while the FSM is in DONE.
- result  output  WIDTH  current accumulator; holds its value until the next accept.
- borrow  output  1  sticky underflow flag for the current operation.
- zero  output  1  high when result == 0; combinational from result.

## Operation
- FSM states and transitions:
  - IDLE: on accept, acc <= start_value, rem <= repeat_cnt, mode latched, borrow <= 0. Next state is DONE if repeat_cnt == 0, otherwise RUN.
  - RUN: on each edge, acc <= f(acc) and rem <= rem - 1. When rem == 1, next state is DONE; otherwise stay in RUN.
  - DONE: the next edge always returns to IDLE. A start seen here is ignored.
- Subtraction f(acc):
  - Wrap mode: (acc - STEP) mod 2^WIDTH. borrow <= 1 if acc < STEP.
  - Saturate mode: 0 if acc < STEP, otherwise acc - STEP. borrow <= 1 if acc < STEP.
  - borrow is OR-accumulated over all steps. It is cleared only by the next accept or by reset.
- STEP = 0: acc is unchanged, borrow stays 0, and the operation still takes n RUN cycles.
- Requests arriving in RUN or DONE are dropped. There is no queueing, and the requester must hold start until in_ready is seen.
- Reset values (asynchronous, applied immediately on rst_n low, including mid-RUN):
  - state = IDLE, acc = 0, rem = 0, borrow = 0, latched mode = 0.
  - Resulting outputs: in_ready=1, busy=0, done=0, result=0, borrow=0, zero=1.
  - Any operation in progress is abandoned with no done pulse.
- Deassertion of rst_n is synchronous to the design's clock domain; the block needs no internal synchronizer.

## Timing
- Accept happens at edge E0. Subtraction k is applied at edge Ek, for k = 1..n.
- done is high in the cycle following edge En, with the final result and borrow already valid. in_ready rises one cycle later.
- Latency from accept to done is n+1 edges when n ≥ 1, and 1 edge when n = 0.
- Back-to-back throughput is one operation every n+2 cycles, or 2 cycles when n = 0.
- Simultaneous events:
  - start=1 in the DONE cycle is not accepted.
  - A start held continuously from the DONE cycle into IDLE is accepted at the first IDLE edge.
- Maximum n is 2^CNT_W - 1. The rem counter never wraps, because the FSM leaves RUN when rem == 1.

## Test plan
- Reset: assert rst_n=0 mid-RUN, asynchronously and between clock edges. Required response: outputs immediately become in_ready=1, busy=0, done=0, result=0, borrow=0, zero=1, and no done pulse follows after release.
- Wrap, one step: start_value=7, repeat_cnt=1, sat_mode=0. Required response: done in the cycle after E1, result=5, borrow=0, zero=0.
- Wrap underflow: start_value=3, repeat_cnt=3, sat_mode=0. Required response: result goes 3, 1, 7, 5 across E0..E3; done after E3 with result=5 and borrow=1.
- Saturate: start_value=3, repeat_cnt=3, sat_mode=1. Required response: result goes 3, 1, 0, 0; done after E3 with result=0, borrow=1, zero=1.
- Zero count: start_value=6, repeat_cnt=0. Required response: done in the cycle after E0, result=6, borrow=0, busy never high.
- Dropped request: during a RUN with repeat_cnt=4, pulse start with start_value=1 in the RUN and DONE cycles. Required response: the first operation completes unaffected and in_ready=0 during those cycles. A start held from DONE into IDLE is then accepted at the next edge, with borrow cleared.
